security_arming_fsm: RTL and testbench
======================================

Name: security_arming_fsm

Overview:
- Sequences the home security function.
- Tracks arm/disarm requests, runs exit and entry delay countdowns, and detects intrusion and open-window events.
- Drives the enable that lets the door/window lock logic engage, plus a timed siren output.
- Sits between the user keypad/remote interface and the lock controller. It consumes the same person count that the lock logic uses.

Parameters:
- PERSON_WIDTH, 4, width of person_count_i (matches PERSON_COUNTER_DATA_WIDTH).
- DELAY_WIDTH, 8, width of the countdown counter and remaining_o.
- EXIT_TICKS, 30, tick_i pulses allowed to leave after arming. Must be 1..2^DELAY_WIDTH-1.
- ENTRY_TICKS, 15, tick_i pulses allowed to disarm after entry is detected. Same range.
- SIREN_TICKS, 60, tick_i pulses that siren_o stays high once ALARM is entered. Same range.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle timebase strobe (e.g. 1 Hz); counters only decrement on it.
- arm_req_i  in  1  one-cycle arm request.
- disarm_req_i  in  1  one-cycle validated disarm request (code already checked upstream).
- person_count_i  in  PERSON_WIDTH  current number of people in the home.
- door_open_i  in  1  any door open (level).
- window_open_i  in  1  any window open (level).
- security_control_valid_o  out  1  lock enable to the lock controller.
- siren_o  out  1  siren drive.
- arm_reject_o  out  1  one-cycle pulse: arming refused or aborted.
- state_o  out  3  current state code.
- remaining_o  out  DELAY_WIDTH  current countdown value.

Behaviour:
- Reset (rst_i=1 at a clock edge): state DISARMED, counter 0, siren_o 0, arm_reject_o 0, security_control_valid_o 0. Reset mid-countdown or mid-alarm aborts immediately.
- State codes: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. Codes 5-7 are illegal and go to DISARMED on the next edge.
- All outputs are registered and decoded from the state register (Moore). They change one cycle after the input that causes a transition.
- security_control_valid_o = 1 in ARMED and ALARM; 0 otherwise (in EXIT and ENTRY the doors must stay usable).
- Global priority in every state: disarm_req_i → DISARMED and counter 0. It beats every other event in the same cycle, including arm_req_i and timer expiry.
- DISARMED:
  - arm_req_i with window_open_i=1 → stay, arm_reject_o=1 for one cycle.
  - arm_req_i with window_open_i=0 → EXIT, counter loads EXIT_TICKS.
- EXIT:
  - window_open_i=1 → DISARMED plus reject pulse.
  - Otherwise each tick_i decrements the counter.
  - A tick_i while counter==1 is the expiry. If person_count_i==0 and door_open_i==0 → ARMED, counter 0; else → DISARMED plus reject pulse.
  - arm_req_i is ignored here (no reload).
- ARMED:
  - window_open_i=1 → ALARM; this has priority over the door event.
  - Otherwise door_open_i=1 or person_count_i!=0 → ENTRY, counter loads ENTRY_TICKS.
  - arm_req_i is ignored.
- ENTRY:
  - window_open_i=1 → ALARM.
  - tick_i decrements the counter; expiry (tick_i at counter==1) → ALARM.
  - Door closing or the count returning to 0 does NOT return to ARMED.
- ALARM:
  - On entry, counter loads SIREN_TICKS and siren_o=1.
  - tick_i decrements; at expiry siren_o=0 and counter=0.
  - The state stays ALARM (locks held) until disarm_req_i.
  - New window or door events do not retrigger the siren.
- Counter never wraps: with no tick_i it holds; at 0 with tick_i it holds 0.
- tick_i coincident with a state-entering load: the load wins and no decrement occurs that cycle.
- Delay length: exactly N tick_i pulses after the load cycle; the transition happens on the edge of the Nth tick.

Test Plan:
- Reset, then arm_req_i with count=0, doors/windows closed, EXIT_TICKS=3, three ticks → state 1 then 2; valid_o=1 one cycle after the 3rd tick; remaining_o steps 3,2,1,0.
- Arm, count=1 at the 3rd tick → state returns to 0; arm_reject_o exactly one cycle high; valid_o stays 0.
- From ARMED, door_open_i pulse, ENTRY_TICKS=2, disarm_req_i after 1 tick → ENTRY, then DISARMED; siren_o never 1.
- From ARMED, door open with no disarm, 2 ticks → ALARM; siren_o=1 for SIREN_TICKS=4 ticks then 0; valid_o stays 1; state stays 4 until disarm_req_i.
- arm_req_i and disarm_req_i in the same cycle in DISARMED → stays 0. window_open_i=1 with arm_req_i → reject pulse, state 0.
- From ARMED, window_open_i and door_open_i in the same cycle → ALARM directly (not ENTRY). Assert rst_i during ALARM → all outputs 0 next cycle.

Source files
------------

// File: rtl/security_arming_fsm.sv
// Home security arming sequencer: exit/entry delays, intrusion detection,
// lock enable and timed siren. All outputs are decoded from registered state.
module security_arming_fsm #(
  parameter int PERSON_WIDTH = 4,
  parameter int DELAY_WIDTH  = 8,
  parameter int EXIT_TICKS   = 30,
  parameter int ENTRY_TICKS  = 15,
  parameter int SIREN_TICKS  = 60
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tick_i,
  input  logic                    arm_req_i,
  input  logic                    disarm_req_i,
  input  logic [PERSON_WIDTH-1:0] person_count_i,
  input  logic                    door_open_i,
  input  logic                    window_open_i,
  output logic                    security_control_valid_o,
  output logic                    siren_o,
  output logic                    arm_reject_o,
  output logic [2:0]              state_o,
  output logic [DELAY_WIDTH-1:0]  remaining_o
);

  // state    | meaning
  // DISARMED | idle, locks free
  // EXIT     | exit delay running after arm request
  // ARMED    | armed, locks enabled, watching doors/windows
  // ENTRY    | entry delay running, waiting for disarm
  // ALARM    | intrusion, locks held, siren timed
  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } state_t;

  localparam logic [DELAY_WIDTH-1:0] ONE = DELAY_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   siren_q, siren_d;
  logic                   reject_q, reject_d;
  logic                   occupied;
  logic                   expiry;

  assign occupied = (person_count_i != '0);
  assign expiry   = tick_i && (cnt_q == ONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= DISARMED;
      cnt_q    <= '0;
      siren_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      siren_q  <= siren_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    siren_d  = siren_q;
    reject_d = 1'b0;

    if (disarm_req_i) begin
      state_d = DISARMED;
      cnt_d   = '0;
      siren_d = 1'b0;
    end else begin
      unique case (state_q)
        DISARMED: begin
          siren_d = 1'b0;
          cnt_d   = '0;
          if (arm_req_i) begin
            if (window_open_i) begin
              reject_d = 1'b1;
            end else begin
              state_d = EXIT;
              cnt_d   = DELAY_WIDTH'(EXIT_TICKS);
            end
          end
        end
        EXIT: begin
          if (window_open_i) begin
            state_d  = DISARMED;
            cnt_d    = '0;
            reject_d = 1'b1;
          end else if (expiry) begin
            cnt_d = '0;
            if (!occupied && !door_open_i) begin
              state_d = ARMED;
            end else begin
              state_d  = DISARMED;
              reject_d = 1'b1;
            end
          end else if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end
        end
        ARMED: begin
          // Window intrusion skips the entry delay entirely.
          if (window_open_i) begin
            state_d = ALARM;
            cnt_d   = DELAY_WIDTH'(SIREN_TICKS);
            siren_d = 1'b1;
          end else if (door_open_i || occupied) begin
            state_d = ENTRY;
            cnt_d   = DELAY_WIDTH'(ENTRY_TICKS);
          end
        end
        ENTRY: begin
          if (window_open_i || expiry) begin
            state_d = ALARM;
            cnt_d   = DELAY_WIDTH'(SIREN_TICKS);
            siren_d = 1'b1;
          end else if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end
        end
        ALARM: begin
          if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) siren_d = 1'b0;
          end
        end
        default: begin
          state_d = DISARMED;
          cnt_d   = '0;
          siren_d = 1'b0;
        end
      endcase
    end
  end

  assign security_control_valid_o = (state_q == ARMED) || (state_q == ALARM);
  assign siren_o                  = siren_q;
  assign arm_reject_o             = reject_q;
  assign state_o                  = state_q;
  assign remaining_o              = cnt_q;

endmodule

// File: tb/tb_security_arming_fsm.sv
// Randomized scoreboard bench for security_arming_fsm against a tick-counting
// reference model (elapsed ticks vs. delay limit per phase).
module tb_security_arming_fsm;

  localparam int PW = 4;
  localparam int DW = 8;
  localparam int EXIT_T  = 3;
  localparam int ENTRY_T = 2;
  localparam int SIREN_T = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic [PW-1:0] person = '0;
  logic          door = 1'b0;
  logic          window = 1'b0;
  logic          valid_o, siren_o, reject_o;
  logic [2:0]    state_o;
  logic [DW-1:0] rem_o;

  security_arming_fsm #(
    .PERSON_WIDTH(PW), .DELAY_WIDTH(DW),
    .EXIT_TICKS(EXIT_T), .ENTRY_TICKS(ENTRY_T), .SIREN_TICKS(SIREN_T)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .arm_req_i(arm),
    .disarm_req_i(disarm), .person_count_i(person), .door_open_i(door),
    .window_open_i(window), .security_control_valid_o(valid_o),
    .siren_o(siren_o), .arm_reject_o(reject_o), .state_o(state_o),
    .remaining_o(rem_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int rem;
    bit sir;
    bit rej;
    bit vld;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: phase name, delay limit, and ticks elapsed in that phase.
  int m_phase = 0;   // 0 idle,1 leaving,2 armed,3 entering,4 alarm
  int m_limit = 0;
  int m_seen  = 0;
  bit m_rej   = 0;

  function automatic void enter(input int ph, input int lim);
    m_phase = ph;
    m_limit = lim;
    m_seen  = 0;
  endfunction

  function automatic exp_t model_step(input bit r, a, d, t, input int p,
                                      input bit dr, w);
    exp_t e;
    m_rej = 0;
    if (r || d) begin
      enter(0, 0);
    end else begin
      case (m_phase)
        0: if (a) begin
             if (w) m_rej = 1;
             else enter(1, EXIT_T);
           end
        1: if (w) begin
             enter(0, 0); m_rej = 1;
           end else if (t) begin
             m_seen++;
             if (m_seen == m_limit) begin
               if (p == 0 && !dr) enter(2, 0);
               else begin enter(0, 0); m_rej = 1; end
             end
           end
        2: if (w) enter(4, SIREN_T);
           else if (dr || p != 0) enter(3, ENTRY_T);
        3: if (w) enter(4, SIREN_T);
           else if (t) begin
             m_seen++;
             if (m_seen == m_limit) enter(4, SIREN_T);
           end
        default: if (t && m_seen < m_limit) m_seen++;
      endcase
    end
    e.st  = m_phase;
    e.rem = m_limit - m_seen;
    e.sir = (m_phase == 4) && (m_seen < m_limit);
    e.rej = m_rej;
    e.vld = (m_phase == 2) || (m_phase == 4);
    return e;
  endfunction

  task automatic drive(input bit r, a, d, t, input int p, input bit dr, w);
    @(negedge clk);
    rst = r; arm = a; disarm = d; tick = t;
    person = PW'(p); door = dr; window = w;
    exp_q.push_back(model_step(r, a, d, t, p, dr, w));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0, 0, 0);
  endtask

  // Monitor: DUT presents a full output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks += 5;
        if (int'(state_o) != e.st) begin
          failures++;
          $display("FAIL state t=%0t got=%0d exp=%0d", $time, state_o, e.st);
        end
        if (int'(rem_o) != e.rem) begin
          failures++;
          $display("FAIL remaining t=%0t got=%0d exp=%0d", $time, rem_o, e.rem);
        end
        if (siren_o !== e.sir) begin
          failures++;
          $display("FAIL siren t=%0t got=%b exp=%b", $time, siren_o, e.sir);
        end
        if (reject_o !== e.rej) begin
          failures++;
          $display("FAIL reject t=%0t got=%b exp=%b", $time, reject_o, e.rej);
        end
        if (valid_o !== e.vld) begin
          failures++;
          $display("FAIL valid t=%0t got=%b exp=%b", $time, valid_o, e.vld);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Clean arm through exit delay.
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(1); tk(1); idle(1); tk(2); idle(2);
    // Door opens, disarmed after one entry tick.
    drive(0, 0, 0, 0, 0, 1, 0);
    tk(1); drive(0, 0, 1, 0, 0, 0, 0); idle(1);
    // Someone still home at exit expiry.
    drive(0, 1, 0, 0, 0, 0, 0);
    tk(2); drive(0, 0, 0, 1, 1, 0, 0); idle(2);
    // Entry delay expires into alarm, siren times out, held until disarm.
    drive(0, 1, 0, 0, 0, 0, 0); tk(3);
    drive(0, 0, 0, 0, 0, 1, 0); tk(2); idle(1);
    tk(3); drive(0, 0, 0, 0, 0, 1, 1); tk(3); idle(2);
    drive(0, 0, 1, 0, 0, 0, 0); idle(1);
    // Arm and disarm together; arm with window open.
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1); idle(1);
    // Window and door together from ARMED, then reset during alarm.
    drive(0, 1, 0, 1, 0, 0, 0); tk(3);
    drive(0, 0, 0, 0, 0, 1, 1); tk(1);
    drive(1, 0, 0, 0, 0, 0, 0); idle(2);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 1) == 1),
            (($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 29) == 0));
    end
    idle(1);
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
